// File: rtl/spi_slv_pkg.sv
// Shared encodings and constants for the SPI target register file.
// State encoding is one-hot in a 5-bit vector; bit 4 is spare.
package spi_slv_pkg;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ADDR = 5'b00010,
        S_GAP  = 5'b00100,
        S_DATA = 5'b01000
    } state_e;

    localparam int         ADDR_WR_BIT = 7;
    localparam int         BYTE_BITS   = 8;
    localparam logic [7:0] RD_OOR_VAL  = 8'hFF;

endpackage

// File: rtl/spi_slv_sync.sv
// Two-flop synchroniser for the SPI pins plus a falling-edge detector on sclk.
// sclk/mosi reset to their idle-high level so reset release never fakes a fall.
module spi_slv_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic cs_i,
    output logic mosi_s_o,
    output logic cs_s_o,
    output logic sclk_fall_o
);

    logic [1:0] sclk_q;
    logic [1:0] mosi_q;
    logic [1:0] cs_q;
    logic       sclk_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q      <= 2'b11;
            mosi_q      <= 2'b11;
            cs_q        <= 2'b00;
            sclk_prev_q <= 1'b1;
        end else begin
            sclk_q      <= {sclk_q[0], sclk_i};
            mosi_q      <= {mosi_q[0], mosi_i};
            cs_q        <= {cs_q[0], cs_i};
            sclk_prev_q <= sclk_q[1];
        end
    end

    assign mosi_s_o    = mosi_q[1];
    assign cs_s_o      = cs_q[1];
    assign sclk_fall_o = sclk_prev_q & ~sclk_q[1];

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI target with a byte register file, oversampled on pclk_i.
// Optional error counter output err_cnt_o is enabled by SPI_SLV_ERR_CNT_EN.
module spi_slave_regfile
    import spi_slv_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TO_CYC = 64
) (
    input  logic                     pclk_i,
    input  logic                     prst_i,
    input  logic                     sclk_i,
    input  logic                     mosi_i,
    input  logic                     cs_i,
    output logic                     miso_o,
    input  logic [$clog2(DEPTH)-1:0] peek_addr_i,
    output logic [7:0]               peek_data_o,
    output logic                     frame_done_o,
    output logic [7:0]               last_addr_o,
    output logic [7:0]               last_data_o,
    output logic                     busy_o
`ifdef SPI_SLV_ERR_CNT_EN
    ,
    output logic [7:0]               err_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TO_CYC);

    logic mosi_s, cs_s, sclk_fall;

    spi_slv_sync u_sync (
        .clk_i       (pclk_i),
        .rst_i       (prst_i),
        .sclk_i      (sclk_i),
        .mosi_i      (mosi_i),
        .cs_i        (cs_i),
        .mosi_s_o    (mosi_s),
        .cs_s_o      (cs_s),
        .sclk_fall_o (sclk_fall)
    );

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      addr_sr_q, addr_sr_d;
    logic [7:0]      wr_sr_q, wr_sr_d;
    logic [7:0]      rd_sr_q, rd_sr_d;
    logic            miso_q, miso_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      last_addr_q, last_addr_d;
    logic [7:0]      last_data_q, last_data_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]      regs_q [DEPTH];
    logic [7:0]      peek_q;
    logic            in_range, we, counting, timeout;
    logic [7:0]      rd_val;

    // addr_sr[6:0] is complete before the 8th address fall, so lookup can use it directly
    assign in_range = int'(addr_sr_q[6:0]) < DEPTH;
    assign rd_val   = in_range ? regs_q[addr_sr_q[AW-1:0]] : RD_OOR_VAL;
    assign counting = (state_q == S_ADDR || state_q == S_DATA) && bit_cnt_q != 3'd0;
    assign timeout  = counting && !sclk_fall && to_cnt_q == TW'(TO_CYC - 1);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        addr_sr_d    = addr_sr_q;
        wr_sr_d      = wr_sr_q;
        rd_sr_d      = rd_sr_q;
        miso_d       = miso_q;
        frame_done_d = 1'b0;
        last_addr_d  = last_addr_q;
        last_data_d  = last_data_q;
        we           = 1'b0;
        to_cnt_d     = (counting && !sclk_fall) ? to_cnt_q + TW'(1) : '0;

        if ((state_q != S_IDLE && !cs_s) || timeout) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b1;
            to_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_d    = 1'b1;
                    bit_cnt_d = 3'd0;
                    if (cs_s) state_d = S_ADDR;
                end
                S_ADDR: if (sclk_fall) begin
                    addr_sr_d[bit_cnt_q] = mosi_s;
                    bit_cnt_d            = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_GAP;
                        if (!mosi_s) begin
                            rd_sr_d = rd_val;
                            miso_d  = rd_val[0];
                        end
                    end
                end
                S_GAP: if (sclk_fall) begin
                    wr_sr_d[0] = mosi_s;
                    if (!addr_sr_q[ADDR_WR_BIT]) miso_d = rd_sr_q[1];
                    bit_cnt_d  = 3'd1;
                    state_d    = S_DATA;
                end
                S_DATA: if (sclk_fall) begin
                    wr_sr_d[bit_cnt_q] = mosi_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (!addr_sr_q[ADDR_WR_BIT]) miso_d = rd_sr_q[bit_cnt_q + 3'd1];
                    if (bit_cnt_q == 3'(BYTE_BITS - 1)) begin
                        we           = addr_sr_q[ADDR_WR_BIT] && in_range;
                        frame_done_d = 1'b1;
                        last_addr_d  = addr_sr_q;
                        last_data_d  = addr_sr_q[ADDR_WR_BIT] ? wr_sr_d : rd_sr_q;
                        miso_d       = 1'b1;
                        state_d      = S_ADDR;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            addr_sr_q    <= 8'h00;
            wr_sr_q      <= 8'h00;
            rd_sr_q      <= 8'h00;
            miso_q       <= 1'b1;
            frame_done_q <= 1'b0;
            last_addr_q  <= 8'h00;
            last_data_q  <= 8'h00;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_sr_q    <= addr_sr_d;
            wr_sr_q      <= wr_sr_d;
            rd_sr_q      <= rd_sr_d;
            miso_q       <= miso_d;
            frame_done_q <= frame_done_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    // Peek reads the pre-commit array, so a same-cycle write shows up one cycle later
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
            peek_q <= 8'h00;
        end else begin
            if (we) regs_q[addr_sr_q[AW-1:0]] <= wr_sr_d;
            peek_q <= (int'(peek_addr_i) < DEPTH) ? regs_q[peek_addr_i] : RD_OOR_VAL;
        end
    end

`ifdef SPI_SLV_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       err_evt;

    assign err_evt = (state_q != S_IDLE) &&
                     (!cs_s ? (bit_cnt_q != 3'd0 || state_q == S_GAP) : timeout);

    always_ff @(posedge pclk_i) begin
        if (prst_i)                           err_cnt_q <= 8'h00;
        else if (err_evt && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt_o = err_cnt_q;
`endif

    assign miso_o       = miso_q;
    assign peek_data_o  = peek_q;
    assign frame_done_o = frame_done_q;
    assign last_addr_o  = last_addr_q;
    assign last_data_o  = last_data_q;
    assign busy_o       = state_q != S_IDLE;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile with a frame scoreboard and a register model.
// Build with SPI_SLV_ERR_CNT_EN defined to also check err_cnt_o.
module tb_spi_slave_regfile;

    localparam int HALF = 8;

    logic       pclk = 1'b0;
    logic       prst = 1'b1;
    logic       sclk = 1'b1;
    logic       mosi = 1'b1;
    logic       cs   = 1'b0;
    logic [3:0] peek_addr = 4'd0;
    logic       miso_o, frame_done_o, busy_o;
    logic [7:0] peek_data_o, last_addr_o, last_data_o;
`ifdef SPI_SLV_ERR_CNT_EN
    logic [7:0] err_cnt_o;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  mdl [16];
    logic        watch_idle = 1'b0;
    logic        saw_idle   = 1'b0;

    spi_slave_regfile #(.DEPTH(16), .TO_CYC(64)) dut (
        .pclk_i       (pclk),
        .prst_i       (prst),
        .sclk_i       (sclk),
        .mosi_i       (mosi),
        .cs_i         (cs),
        .miso_o       (miso_o),
        .peek_addr_i  (peek_addr),
        .peek_data_o  (peek_data_o),
        .frame_done_o (frame_done_o),
        .last_addr_o  (last_addr_o),
        .last_data_o  (last_data_o),
        .busy_o       (busy_o)
`ifdef SPI_SLV_ERR_CNT_EN
        ,
        .err_cnt_o    (err_cnt_o)
`endif
    );

    always #5 pclk = ~pclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every frame_done pulse must match the oldest expected {addr,data}
    always @(negedge pclk) begin
        if (watch_idle && !busy_o) saw_idle = 1'b1;
        if (frame_done_o) begin
            check("frame_done_expected", 16'(frame_done_o), 16'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("frame", {last_addr_o, last_data_o}, exp_q.pop_front());
        end
    end

    task automatic spi_bit(input logic b, input logic chk, input logic e);
        mosi = b;
        repeat (HALF) @(negedge pclk);
        if (chk) check("miso_bit", 16'(miso_o), 16'(e));
        sclk = 1'b0;
        repeat (HALF) @(negedge pclk);
        sclk = 1'b1;
    endtask

    task automatic gap();
        mosi = 1'b1;
        repeat (4 * 2 * HALF) @(negedge pclk);
    endtask

    task automatic cs_on();
        @(negedge pclk) cs = 1'b1;
        repeat (4) @(negedge pclk);
    endtask

    task automatic cs_off();
        @(negedge pclk) cs = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rd;
        logic       is_wr;
        is_wr = a[7];
        rd = (a[6:0] < 7'd16) ? mdl[a[3:0]] : 8'hFF;
        exp_q.push_back({a, is_wr ? d : rd});
        for (int i = 0; i < 8; i++) spi_bit(a[i], 1'b0, 1'b0);
        gap();
        for (int i = 0; i < 8; i++) spi_bit(is_wr ? d[i] : 1'b1, !is_wr, rd[i]);
        if (is_wr && a[6:0] < 7'd16) mdl[a[3:0]] = d;
        if (!is_wr) check("miso_idle_after_read", 16'(miso_o), 16'd1);
        gap();
    endtask

    task automatic peek_chk(input int a);
        @(negedge pclk) peek_addr = a[3:0];
        @(negedge pclk);
        check($sformatf("peek[%0d]", a), 16'(peek_data_o), 16'(mdl[a]));
    endtask

    task automatic peek_all();
        for (int a = 0; a < 16; a++) peek_chk(a);
    endtask

    initial begin
        logic       found;
        logic [7:0] old_v;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge pclk);
        prst = 1'b0;
        @(negedge pclk);
        check("rst_miso", 16'(miso_o), 16'd1);
        check("rst_peek", 16'(peek_data_o), 16'd0);
        check("rst_frame_done", 16'(frame_done_o), 16'd0);
        check("rst_last_addr", 16'(last_addr_o), 16'd0);
        check("rst_last_data", 16'(last_data_o), 16'd0);
        check("rst_busy", 16'(busy_o), 16'd0);
`ifdef SPI_SLV_ERR_CNT_EN
        check("rst_err_cnt", 16'(err_cnt_o), 16'd0);
`endif

        // Write then read back over SPI
        cs_on();
        check("busy_after_cs", 16'(busy_o), 16'd1);
        send_frame(8'h83, 8'hA5);
        peek_chk(3);
        send_frame(8'h83, 8'h3C);
        send_frame(8'h03, 8'h00);
        cs_off();
        check("busy_after_cs_drop", 16'(busy_o), 16'd0);

        // Out of range write dropped, read returns FF
        cs_on();
        send_frame(8'h9F, 8'h11);
        send_frame(8'h1F, 8'h00);
        cs_off();
        peek_all();

        // Back-to-back writes in one select
        cs_on();
        send_frame(8'h80, 8'h01);
        send_frame(8'h81, 8'h02);
        send_frame(8'h01, 8'h00);
        cs_off();
        peek_chk(0);
        peek_chk(1);

        // Peek of the address being committed sees old then new value
        @(negedge pclk) peek_addr = 4'd4;
        old_v = mdl[4];
        exp_q.push_back({8'h84, 8'h77});
        cs_on();
        for (int i = 0; i < 8; i++) spi_bit(1'(8'h84 >> i), 1'b0, 1'b0);
        gap();
        for (int i = 0; i < 7; i++) spi_bit(1'(8'h77 >> i), 1'b0, 1'b0);
        mosi = 1'b0;
        repeat (HALF) @(negedge pclk);
        sclk  = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge pclk);
            if (frame_done_o) found = 1'b1;
        end
        check("collide_done_seen", 16'(found), 16'd1);
        check("collide_old", 16'(peek_data_o), 16'(old_v));
        @(negedge pclk);
        check("collide_new", 16'(peek_data_o), 16'h77);
        mdl[4] = 8'h77;
        repeat (HALF) @(negedge pclk);
        sclk = 1'b1;
        gap();
        cs_off();

        // Timeout after 3 address bits, then a clean frame must decode
        cs_on();
        saw_idle   = 1'b0;
        watch_idle = 1'b1;
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, 1'b0);
        repeat (70) @(negedge pclk);
        watch_idle = 1'b0;
        check("timeout_to_idle", 16'(saw_idle), 16'd1);
`ifdef SPI_SLV_ERR_CNT_EN
        check("err_cnt_timeout", 16'(err_cnt_o), 16'd1);
`endif
        send_frame(8'h82, 8'h5A);
        cs_off();
        peek_all();

        // Reset in the data phase of a write
        cs_on();
        for (int i = 0; i < 8; i++) spi_bit(1'(8'h85 >> i), 1'b0, 1'b0);
        gap();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, 1'b0);
        prst = 1'b1;
        @(negedge pclk);
        check("mrst_miso", 16'(miso_o), 16'd1);
        check("mrst_frame_done", 16'(frame_done_o), 16'd0);
        check("mrst_last_addr", 16'(last_addr_o), 16'd0);
        check("mrst_last_data", 16'(last_data_o), 16'd0);
        check("mrst_busy", 16'(busy_o), 16'd0);
        check("mrst_peek", 16'(peek_data_o), 16'd0);
`ifdef SPI_SLV_ERR_CNT_EN
        check("mrst_err_cnt", 16'(err_cnt_o), 16'd0);
`endif
        cs   = 1'b0;
        mosi = 1'b1;
        @(negedge pclk) prst = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        repeat (4) @(negedge pclk);
        peek_all();

        check("sb_drain", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
